// File: rtl/tl_intersection_ctrl.sv
// Two-road intersection sequencer with pedestrian walk phase and emergency pre-emption.
// The phase FSM advances on a prescaled tick. The light outputs are decoded from the
// next state and registered on the same edge as the state, so lights change with zero
// extra latency.
module tl_intersection_ctrl #(
    parameter int GREEN_TICKS  = 8,
    parameter int YELLOW_TICKS = 2,
    parameter int ALLRED_TICKS = 1,
    parameter int WALK_TICKS   = 4,
    parameter int CNT_W        = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        tick_en_i,
    input  logic        ped_req_i,
    input  logic        emerg_req_i,
    output logic [0:2]  ns_lig_o,
    output logic [0:2]  ew_lig_o,
    output logic        walk_o,
    output logic [2:0]  phase_o,
    output logic        ped_pending_o
);

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        AR1   = 3'd2,
        EW_G  = 3'd3,
        EW_Y  = 3'd4,
        AR2   = 3'd5,
        WALK  = 3'd6,
        EMERG = 3'd7
    } state_t;

    localparam logic [0:2] LIGHT_RED    = 3'b100;
    localparam logic [0:2] LIGHT_GREEN  = 3'b010;
    localparam logic [0:2] LIGHT_YELLOW = 3'b001;

    localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] WALK_LOAD   = CNT_W'(WALK_TICKS - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic              pend_q, pend_d;
    logic [0:2]        ns_q, ns_d;
    logic [0:2]        ew_q, ew_d;
    logic              walk_q, walk_d;
    logic              expired;

    // Dwell value loaded on entry to a state; EMERG has no dwell of its own.
    function automatic logic [CNT_W-1:0] loadFor(input state_t s);
        logic [CNT_W-1:0] v;
        case (s)
            NS_G, EW_G: v = GREEN_LOAD;
            NS_Y, EW_Y: v = YELLOW_LOAD;
            WALK:       v = WALK_LOAD;
            default:    v = ALLRED_LOAD;
        endcase
        return v;
    endfunction

    assign expired = tick_en_i && (timer_q == '0);

    // Next-state selection: timed sequence, pedestrian detour and emergency forcing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            NS_G:  if (emerg_req_i || expired) state_d = NS_Y;
            NS_Y:  if (expired) state_d = emerg_req_i ? EMERG : AR1;
            AR1:   if (expired) state_d = emerg_req_i ? EMERG : EW_G;
            EW_G:  if (emerg_req_i || expired) state_d = EW_Y;
            EW_Y:  if (expired) state_d = emerg_req_i ? EMERG : AR2;
            AR2: begin
                if (expired) begin
                    if (emerg_req_i)  state_d = EMERG;
                    else if (pend_q)  state_d = WALK;
                    else              state_d = NS_G;
                end
            end
            WALK: begin
                if (emerg_req_i)  state_d = EMERG;
                else if (expired) state_d = NS_G;
            end
            EMERG: if (!emerg_req_i) state_d = AR2;
            default: state_d = AR2;
        endcase
    end

    // Dwell timer and pedestrian latch follow from the chosen next state.
    always_comb begin
        timer_d = timer_q;
        pend_d  = pend_q | ped_req_i;
        if (state_d != state_q) begin
            timer_d = loadFor(state_d);
        end else if (tick_en_i && (timer_q != '0)) begin
            timer_d = timer_q - 1'b1;
        end
        if ((state_d == WALK) && (state_q != WALK)) begin
            pend_d = 1'b0;
        end
    end

    // Light and walk decode from the next state, so the registers track the state edge.
    always_comb begin
        ns_d   = LIGHT_RED;
        ew_d   = LIGHT_RED;
        walk_d = 1'b0;
        case (state_d)
            NS_G:    ns_d = LIGHT_GREEN;
            NS_Y:    ns_d = LIGHT_YELLOW;
            EW_G:    ew_d = LIGHT_GREEN;
            EW_Y:    ew_d = LIGHT_YELLOW;
            WALK:    walk_d = 1'b1;
            default: ;
        endcase
    end

    // State, timer, pedestrian latch and output registers with synchronous reset into AR2.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= AR2;
            timer_q <= ALLRED_LOAD;
            pend_q  <= 1'b0;
            ns_q    <= LIGHT_RED;
            ew_q    <= LIGHT_RED;
            walk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            ns_q    <= ns_d;
            ew_q    <= ew_d;
            walk_q  <= walk_d;
        end
    end

    assign ns_lig_o      = ns_q;
    assign ew_lig_o      = ew_q;
    assign walk_o        = walk_q;
    assign phase_o       = state_q;
    assign ped_pending_o = pend_q;

endmodule
